// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional perf counters in ifu_fetch are enabled by defining IFU_PERF_CNT_EN.
package ifu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            fault;
    } fetch_entry_t;

    // Instruction addresses must be word aligned on this port.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over push and pop.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // A push into a full FIFO is legal only when a pop frees the slot this cycle.
    assign push_ok_s = push_i & ~flush_i & (~full_o | pop_i);
    assign pop_ok_s  = pop_i & ~flush_i & ~empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok_s) begin
                wr_d = wr_q + PW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_ok_s) begin
                rd_d = rd_q + PW'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are meaningless until the matching count covers them.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, one aligned read per cycle, fetch buffer, redirect/flush.
// Define IFU_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic        imem_wr,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [3:0]  imem_wstrb,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic          halted_q, halted_d;
    logic          live_s;
    logic          pop_s;
    logic          can_push_s;
    logic          fetch_ok_s;
    logic          aligned_s;
    logic          push_s;
    logic          flush_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    assign imem_wr    = 1'b0;
    assign imem_wdata = 32'h0000_0000;
    assign imem_wstrb = 4'b0000;
    assign imem_addr  = pc_q;
    assign out_pc     = head_s.pc;
    assign out_inst   = head_s.inst;
    assign out_fault  = head_s.fault;

    // Issue and handshake logic; redirect and reset suppress both sides of the port.
    always_comb begin
        live_s     = ~rst & ~redirect_valid;
        out_valid  = live_s & ~fifo_empty_s;
        pop_s      = out_valid & out_ready;
        can_push_s = (fifo_count_s < CW'(FIFO_DEPTH)) | pop_s;
        fetch_ok_s = live_s & ~halted_q & can_push_s;
        aligned_s  = ~is_misaligned(pc_q);
        imem_en    = fetch_ok_s & aligned_s;
        push_s     = fetch_ok_s & (~fifo_full_s | pop_s);
        flush_s    = rst | redirect_valid;
        if (aligned_s) begin
            push_entry_s = '{pc: pc_q, inst: imem_rdata, fault: 1'b0};
        end else begin
            push_entry_s = '{pc: pc_q, inst: 32'h0000_0000, fault: 1'b1};
        end
    end

    // PC / halt next-state: a misaligned PC records one fault entry and then parks.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
        end else if (fetch_ok_s) begin
            if (aligned_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                halted_d = 1'b1;
            end
        end else begin
            pc_d     = pc_q;
            halted_d = halted_q;
        end
    end

    // PC and halt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .din_i   (push_entry_s),
        .head_o  (head_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

`ifdef IFU_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall_s;

    assign stall_s        = live_s & ~halted_q & ~can_push_s;
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

    // Free-running perf counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (imem_en) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end
            if (stall_s) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch against a queue-level reference model.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int DEPTH = 2;
    localparam logic [31:0] XMASK = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en, imem_wr;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic [3:0]  imem_wstrb;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_pc, out_inst;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;

    ent_t mq[$];
    ent_t exp_q[$];
    logic [31:0] m_pc = RST_PC;
    logic        m_halted = 1'b0;
    logic        m_en = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_addr = 32'h0;
    ent_t        m_head;
    longint      m_fcnt = 0, m_scnt = 0, m_fsnap = 0, m_ssnap = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ XMASK;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_wr        (imem_wr),
        .imem_addr      (imem_addr),
        .imem_wdata     (imem_wdata),
        .imem_wstrb     (imem_wstrb),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue advanced once per cycle from the inputs.
    always @(negedge clk) begin
        bit pop, room;
        m_en = 1'b0;
        m_valid = 1'b0;
        m_addr = m_pc;
        m_fsnap = m_fcnt;
        m_ssnap = m_scnt;
        if (rst) begin
            mq.delete();
            m_pc = RST_PC;
            m_halted = 1'b0;
            m_fcnt = 0;
            m_scnt = 0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc;
            m_halted = 1'b0;
        end else begin
            m_valid = (mq.size() > 0);
            if (m_valid) m_head = mq[0];
            pop = m_valid && out_ready;
            room = (mq.size() < DEPTH) || pop;
            if (pop) exp_q.push_back(mq.pop_front());
            if (!m_halted && room) begin
                if (m_pc[1:0] == 2'b00) begin
                    m_en = 1'b1;
                    mq.push_back('{m_pc, m_pc ^ XMASK, 1'b0});
                    m_pc = m_pc + 32'd4;
                    m_fcnt++;
                end else begin
                    mq.push_back('{m_pc, 32'h0, 1'b1});
                    m_halted = 1'b1;
                end
            end else if (!m_halted) begin
                m_scnt++;
            end
        end
    end

    // Monitor: compare port behaviour each cycle and pop the scoreboard on handshakes.
    always @(negedge clk) begin
        ent_t e;
        #1;
        chk("imem_en", {63'h0, imem_en}, {63'h0, m_en});
        if (m_en) chk("imem_addr", {32'h0, imem_addr}, {32'h0, m_addr});
        chk("imem_tied", {27'h0, imem_wr, imem_wdata, imem_wstrb}, 64'h0);
        chk("out_valid", {63'h0, out_valid}, {63'h0, m_valid});
        if (m_valid && out_valid) begin
            chk("head_pc", {32'h0, out_pc}, {32'h0, m_head.pc});
            chk("head_inst", {32'h0, out_inst}, {32'h0, m_head.inst});
            chk("head_fault", {63'h0, out_fault}, {63'h0, m_head.fault});
        end
        if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h expected no entry at %0t", out_pc, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", {32'h0, out_pc}, {32'h0, e.pc});
                chk("sb_inst", {32'h0, out_inst}, {32'h0, e.inst});
                chk("sb_fault", {63'h0, out_fault}, {63'h0, e.fault});
            end
        end
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, m_fsnap);
        chk("perf_stall", perf_stall_cnt, m_ssnap);
`endif
    end

    task automatic run(input int n, input logic r, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
        for (int i = 0; i < n; i++) begin
            rst = r;
            redirect_valid = rv;
            redirect_pc = rpc;
            out_ready = rdy;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset then free-run.
        run(2, 1'b1, 1'b0, 32'h0, 1'b1);
        run(6, 1'b0, 1'b0, 32'h0, 1'b1);
        // Backpressure then release.
        run(1, 1'b1, 1'b0, 32'h0, 1'b1);
        run(5, 1'b0, 1'b0, 32'h0, 1'b0);
        run(4, 1'b0, 1'b0, 32'h0, 1'b1);
        // Redirect while full.
        run(3, 1'b0, 1'b0, 32'h0, 1'b0);
        run(1, 1'b0, 1'b1, 32'h8000_0100, 1'b1);
        run(5, 1'b0, 1'b0, 32'h0, 1'b1);
        // Misaligned target, halt, then resume.
        run(1, 1'b0, 1'b1, 32'h8000_0102, 1'b1);
        run(4, 1'b0, 1'b0, 32'h0, 1'b1);
        run(1, 1'b0, 1'b1, 32'h8000_0200, 1'b1);
        run(4, 1'b0, 1'b0, 32'h0, 1'b1);
        // Back-to-back redirects: last wins.
        run(1, 1'b0, 1'b1, 32'h8000_0300, 1'b1);
        run(1, 1'b0, 1'b1, 32'h8000_0400, 1'b1);
        run(4, 1'b0, 1'b0, 32'h0, 1'b1);
        // Reset mid-stream with entries buffered.
        run(3, 1'b0, 1'b0, 32'h0, 1'b0);
        run(1, 1'b1, 1'b0, 32'h0, 1'b0);
        run(4, 1'b0, 1'b0, 32'h0, 1'b1);
        // Free-running then stalled window for the counters.
        run(1, 1'b1, 1'b0, 32'h0, 1'b1);
        run(10, 1'b0, 1'b0, 32'h0, 1'b1);
        run(6, 1'b0, 1'b0, 32'h0, 1'b0);
        run(3, 1'b0, 1'b0, 32'h0, 1'b1);
        // PC wrap at the top of the address space.
        run(1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        run(5, 1'b0, 1'b0, 32'h0, 1'b1);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, rv, rdy;
            logic [31:0] tgt;
            r = ($urandom_range(0, 149) == 0);
            rv = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 3) == 0) tgt = tgt + 32'($urandom_range(1, 3));
            run(1, r, rv, tgt, rdy);
        end
        run(1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("sb_drain", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
